// File: rtl/stacker_pkg.sv
// Shared definitions for the LED-matrix stacker engine: state encodings,
// block direction constants and the initial-block mask helper.
package stacker_pkg;

  // Legacy-compatible state encodings (plain constants, not an enum type)
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLEAR = 3'd1;
  localparam state_t S_MOVE  = 3'd2;
  localparam state_t S_CHECK = 3'd3;
  localparam state_t S_ALIGN = 3'd4;
  localparam state_t S_WIN   = 3'd5;
  localparam state_t S_LOSE  = 3'd6;

  // RIGHT moves the block toward column 0
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Widest matrix row the mask helper can build
  localparam int MASK_MAX_W = 64;

  // Mask with the top len bits of a width-bit row set (left-justified block)
  function automatic logic [MASK_MAX_W-1:0] left_mask(input int width, input int len);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if ((i < width) && (i >= width - len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stacker_tick.sv
// Programmable step prescaler: pulses tick for one cycle when the count
// reaches period-1, then wraps to zero. clear dominates enable.
module stacker_tick #(
  parameter int TICK_W = 24
) (
  input  logic              updateClk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [TICK_W-1:0] period,
  output logic              tick
);

  logic [TICK_W-1:0] count;
  logic              at_end;

  assign at_end = (count == period - TICK_W'(1));
  assign tick   = enable & at_end;

  // Free-running count while enabled, wrapping on the terminal value
  always_ff @(posedge updateClk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_end ? '0 : count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/stacker_engine.sv
// Stacker game engine: bounces a block along the active row, freezes it on a
// button press, ANDs it with the row below and climbs, speeding up per row.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a press to start a game
//   CLEAR   | blanking display rows 0..ROWS-1, one per cycle
//   MOVE    | block bouncing on the active row, stepping on each tick
//   CHECK   | AND captured block with row below, write result, score
//   ALIGN   | left-justify the surviving block before the next row
//   WIN     | all rows placed; wait for a press
//   LOSE    | block missed entirely; wait for a press
module stacker_engine
  import stacker_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ROWS        = 8,
  parameter int INIT_LEN    = 3,
  parameter int TICK_W      = 24,
  parameter int PERIOD_INIT = 5_000_000,
  parameter int PERIOD_STEP = 500_000,
  parameter int PERIOD_MIN  = 1_000_000
) (
  input  logic                       updateClk,
  input  logic                       reset_n,
  input  logic                       btn,
  output logic [WIDTH-1:0]           val,
  output logic [$clog2(ROWS)-1:0]    rowIndex,
  output logic                       writeStrobe,
  output logic [$clog2(ROWS+1)-1:0]  level,
  output logic                       win,
  output logic                       lose
);

  localparam int RW = $clog2(ROWS);
  localparam int LW = $clog2(ROWS + 1);

  localparam logic [MASK_MAX_W-1:0] INIT_FULL = left_mask(WIDTH, INIT_LEN);
  localparam logic [WIDTH-1:0]      INIT_MASK = INIT_FULL[WIDTH-1:0];

  localparam logic [TICK_W-1:0] P_INIT = TICK_W'(PERIOD_INIT);
  localparam logic [TICK_W-1:0] P_STEP = TICK_W'(PERIOD_STEP);
  localparam logic [TICK_W-1:0] P_MIN  = TICK_W'(PERIOD_MIN);
  // Periods at or above this can take a full step without dropping below the floor
  localparam logic [TICK_W:0]   P_FLOOR = (TICK_W+1)'(PERIOD_MIN) + (TICK_W+1)'(PERIOD_STEP);

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t            state;
  logic [WIDTH-1:0]  curr;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  captured;
  logic              dir;
  logic [TICK_W-1:0] period;
  logic [RW-1:0]     row;
  logic              btn_d;

  logic              btn_edge;
  logic              tick;
  logic              tick_clear;
  logic              tick_en;
  logic [WIDTH-1:0]  placed;
  logic [TICK_W-1:0] period_next;
  logic [WIDTH-1:0]  curr_step;
  logic              dir_step;

  assign btn_edge    = btn & ~btn_d;
  assign placed      = captured & prev;
  assign period_next = ({1'b0, period} >= P_FLOOR) ? (period - P_STEP) : P_MIN;
  assign tick_en     = (state == S_MOVE);
  // Counter restarts as MOVE is entered, both from CLEAR and from ALIGN
  assign tick_clear  = ((state == S_CLEAR) && (row == LAST_ROW)) ||
                       ((state == S_ALIGN) && curr[WIDTH-1]);
  assign win         = (state == S_WIN);
  assign lose        = (state == S_LOSE);

  stacker_tick #(
    .TICK_W (TICK_W)
  ) u_tick (
    .updateClk (updateClk),
    .reset_n   (reset_n),
    .clear     (tick_clear),
    .enable    (tick_en),
    .period    (period),
    .tick      (tick)
  );

  // Next block position: bounce off an edge, otherwise keep travelling
  always_comb begin
    dir_step  = dir;
    curr_step = curr;
    if ((dir == DIR_RIGHT) && curr[0]) begin
      dir_step  = DIR_LEFT;
      curr_step = curr << 1;
    end else if ((dir == DIR_LEFT) && curr[WIDTH-1]) begin
      dir_step  = DIR_RIGHT;
      curr_step = curr >> 1;
    end else if (dir == DIR_RIGHT) begin
      curr_step = curr >> 1;
    end else begin
      curr_step = curr << 1;
    end
  end

  // Button history for rising-edge detection
  always_ff @(posedge updateClk or negedge reset_n) begin
    if (!reset_n) btn_d <= 1'b0;
    else          btn_d <= btn;
  end

  // Game FSM with datapath; display writes are registered and appear next cycle
  always_ff @(posedge updateClk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      curr        <= '0;
      prev        <= '1;
      captured    <= '0;
      dir         <= DIR_RIGHT;
      period      <= P_INIT;
      row         <= '0;
      val         <= '0;
      rowIndex    <= '0;
      writeStrobe <= 1'b0;
      level       <= '0;
    end else begin
      writeStrobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (btn_edge) begin
            state       <= S_CLEAR;
            row         <= '0;
            rowIndex    <= '0;
            val         <= '0;
            writeStrobe <= 1'b1;
          end
        end
        S_CLEAR: begin
          // row doubles as the clear counter; the first blank write was issued from IDLE
          if (row == LAST_ROW) begin
            state       <= S_MOVE;
            curr        <= INIT_MASK;
            prev        <= '1;
            dir         <= DIR_RIGHT;
            period      <= P_INIT;
            level       <= '0;
            row         <= '0;
            rowIndex    <= '0;
            val         <= INIT_MASK;
            writeStrobe <= 1'b1;
          end else begin
            row         <= row + RW'(1);
            rowIndex    <= row + RW'(1);
            val         <= '0;
            writeStrobe <= 1'b1;
          end
        end
        S_MOVE: begin
          // A press wins over a coincident tick, so the pre-shift block is kept
          if (btn_edge) begin
            captured <= curr;
            state    <= S_CHECK;
          end else if (tick) begin
            curr        <= curr_step;
            dir         <= dir_step;
            val         <= curr_step;
            rowIndex    <= row;
            writeStrobe <= 1'b1;
          end
        end
        S_CHECK: begin
          val         <= placed;
          rowIndex    <= row;
          writeStrobe <= 1'b1;
          if (placed == '0) begin
            state <= S_LOSE;
          end else begin
            level <= level + LW'(1);
            if (row == LAST_ROW) begin
              state <= S_WIN;
            end else begin
              row   <= row + RW'(1);
              prev  <= placed;
              curr  <= placed;
              state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          if (curr[WIDTH-1]) begin
            period      <= period_next;
            dir         <= DIR_RIGHT;
            state       <= S_MOVE;
            val         <= curr;
            rowIndex    <= row;
            writeStrobe <= 1'b1;
          end else begin
            curr <= curr << 1;
          end
        end
        S_WIN, S_LOSE: begin
          if (btn_edge) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stacker_engine.sv
// Scoreboard bench for the stacker engine: expected display writes are queued
// as stimulus is applied and checked by a monitor as strobes appear.
module tb_stacker_engine;

  localparam int WIDTH  = 8;
  localparam int ROWS   = 8;
  localparam int P_INIT = 10;
  localparam int P_STEP = 3;
  localparam int P_MIN  = 4;
  localparam logic [7:0] INIT_PAT = 8'b1110_0000;

  logic       updateClk = 1'b0;
  logic       reset_n   = 1'b1;
  logic       btn       = 1'b0;
  logic [7:0] val;
  logic [2:0] rowIndex;
  logic       writeStrobe;
  logic [3:0] level;
  logic       win;
  logic       lose;

  stacker_engine #(
    .WIDTH       (WIDTH),
    .ROWS        (ROWS),
    .INIT_LEN    (3),
    .TICK_W      (24),
    .PERIOD_INIT (P_INIT),
    .PERIOD_STEP (P_STEP),
    .PERIOD_MIN  (P_MIN)
  ) dut (
    .updateClk   (updateClk),
    .reset_n     (reset_n),
    .btn         (btn),
    .val         (val),
    .rowIndex    (rowIndex),
    .writeStrobe (writeStrobe),
    .level       (level),
    .win         (win),
    .lose        (lose)
  );

  always #5 updateClk = ~updateClk;

  typedef struct packed {
    logic [2:0] row;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t got_w;
  wr_t want_w;

  int n_cmp   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int last_wr = 0;
  int prev_wr = 0;

  // bench model of the game
  logic [7:0] m_curr;
  logic [7:0] m_prev;
  logic       m_left;
  int         m_row;
  int         m_level;
  int         m_period;

  // write monitor, sampling 1 time unit after each rising edge
  always begin
    @(posedge updateClk);
    #1;
    cyc++;
    if (writeStrobe === 1'b1) begin
      got_w   = {rowIndex, val};
      prev_wr = last_wr;
      last_wr = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got row %0d val %b, no write expected", rowIndex, val);
      end else begin
        want_w = exp_q.pop_front();
        if (got_w !== want_w) begin
          n_err++;
          $display("FAIL write: got row %0d val %b, expected row %0d val %b",
                   got_w.row, got_w.data, want_w.row, want_w.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] step(input logic [7:0] c, input logic left);
    if (!left && c[0])     return {1'b1, c << 1};
    else if (left && c[7]) return {1'b0, c >> 1};
    else if (left)         return {1'b1, c << 1};
    else                   return {1'b0, c >> 1};
  endfunction

  task automatic model_start();
    for (int r = 0; r < ROWS; r++) exp_q.push_back({3'(r), 8'h00});
    exp_q.push_back({3'd0, INIT_PAT});
    m_curr   = INIT_PAT;
    m_prev   = 8'hFF;
    m_left   = 1'b0;
    m_row    = 0;
    m_level  = 0;
    m_period = P_INIT;
  endtask

  task automatic model_tick();
    logic [8:0] s;
    s      = step(m_curr, m_left);
    m_left = s[8];
    m_curr = s[7:0];
    exp_q.push_back({3'(m_row), m_curr});
  endtask

  task automatic model_press();
    logic [7:0] placed;
    placed = m_curr & m_prev;
    exp_q.push_back({3'(m_row), placed});
    if (placed == 8'h00) return;
    m_level++;
    if (m_row == ROWS - 1) return;
    m_row++;
    m_prev = placed;
    m_curr = placed;
    while (!m_curr[7]) m_curr = m_curr << 1;
    m_left   = 1'b0;
    m_period = (m_period - P_STEP < P_MIN) ? P_MIN : m_period - P_STEP;
    exp_q.push_back({3'(m_row), m_curr});
  endtask

  task automatic press();
    btn = 1'b1;
    @(negedge updateClk);
    btn = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge updateClk);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d writes still pending after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (val !== 8'h00)      begin n_err++; $display("FAIL reset_val: got %b, expected 0", val); end
    n_cmp++; if (rowIndex !== 3'd0)  begin n_err++; $display("FAIL reset_row: got %0d, expected 0", rowIndex); end
    n_cmp++; if (writeStrobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b, expected 0", writeStrobe); end
    n_cmp++; if (level !== 4'd0)     begin n_err++; $display("FAIL reset_level: got %0d, expected 0", level); end
    n_cmp++; if ({win, lose} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got win %b lose %b, expected 0 0", win, lose); end
    repeat (3) @(negedge updateClk);
    reset_n = 1'b1;
    repeat (10) @(negedge updateClk);
  endtask

  task automatic test_clear();
    model_start();
    press();
    @(negedge updateClk);
    press();   // lands inside CLEAR and must be ignored
    wait_drain(40);
    n_cmp++;
    if ((last_wr - prev_wr) != 1) begin
      n_err++; $display("FAIL clear_to_move_gap: got %0d cycles, expected 1", last_wr - prev_wr);
    end
    n_cmp++;
    if (level !== 4'd0) begin n_err++; $display("FAIL clear_level: got %0d, expected 0", level); end
  endtask

  task automatic test_lose();
    model_press();
    press();
    wait_drain(20);
    n_cmp++;
    if (level !== 4'd1) begin n_err++; $display("FAIL lose_level_row0: got %0d, expected 1", level); end
    repeat (5) model_tick();
    wait_drain(100);
    n_cmp++;
    if ((last_wr - prev_wr) != 7) begin
      n_err++; $display("FAIL lose_tick_gap: got %0d cycles, expected 7", last_wr - prev_wr);
    end
    model_press();
    press();
    wait_drain(20);
    n_cmp++;
    if ({win, lose} !== 2'b01) begin n_err++; $display("FAIL lose_flags: got win %b lose %b, expected 0 1", win, lose); end
    n_cmp++;
    if (level !== 4'd1) begin n_err++; $display("FAIL lose_level_held: got %0d, expected 1", level); end
    repeat (20) @(negedge updateClk);
    press();
    n_cmp++;
    if ({win, lose} !== 2'b00) begin n_err++; $display("FAIL lose_exit: got win %b lose %b, expected 0 0", win, lose); end
    repeat (20) @(negedge updateClk);
    n_cmp++;
    if (level !== 4'd1) begin n_err++; $display("FAIL idle_level_held: got %0d, expected 1", level); end
  endtask

  task automatic test_place_align();
    model_start();
    press();
    wait_drain(40);
    model_press();
    press();
    wait_drain(20);
    n_cmp++;
    if ((last_wr - prev_wr) != 1) begin
      n_err++; $display("FAIL align0_gap: got %0d cycles, expected 1", last_wr - prev_wr);
    end
    n_cmp++;
    if (level !== 4'd1) begin n_err++; $display("FAIL place_level1: got %0d, expected 1", level); end
    model_tick();
    wait_drain(30);
    model_press();
    press();
    wait_drain(20);
    n_cmp++;
    if ((last_wr - prev_wr) != 2) begin
      n_err++; $display("FAIL align1_gap: got %0d cycles, expected 2", last_wr - prev_wr);
    end
    n_cmp++;
    if (level !== 4'd2) begin n_err++; $display("FAIL place_level2: got %0d, expected 2", level); end
  endtask

  task automatic test_hold_and_same_tick();
    logic [8:0] nxt;
    int k;
    model_press();
    // queue moves until the block sits where a post-shift capture would miss
    k = 0;
    while (k < 60) begin
      model_tick();
      k++;
      nxt = step(m_curr, m_left);
      if (((m_curr & m_prev) != 8'h00) && ((nxt[7:0] & m_prev) == 8'h00) &&
          (k * m_period > 60)) break;
    end
    btn = 1'b1;
    repeat (50) @(negedge updateClk);
    btn = 1'b0;
    wait_drain(600);
    n_cmp++;
    if (level !== 4'd3) begin n_err++; $display("FAIL hold_single_check: got level %0d, expected 3", level); end
    repeat (m_period - 1) @(negedge updateClk);
    model_press();
    press();
    wait_drain(20);
    n_cmp++;
    if ({win, lose} !== 2'b00) begin n_err++; $display("FAIL same_tick_flags: got win %b lose %b, expected 0 0", win, lose); end
    n_cmp++;
    if (level !== 4'(m_level)) begin n_err++; $display("FAIL same_tick_level: got %0d, expected %0d", level, m_level); end
  endtask

  task automatic test_async_reset();
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (val !== 8'h00)     begin n_err++; $display("FAIL areset_val: got %b, expected 0", val); end
    n_cmp++; if (rowIndex !== 3'd0) begin n_err++; $display("FAIL areset_row: got %0d, expected 0", rowIndex); end
    n_cmp++; if (level !== 4'd0)    begin n_err++; $display("FAIL areset_level: got %0d, expected 0", level); end
    n_cmp++; if ({writeStrobe, win, lose} !== 3'b000) begin
      n_err++; $display("FAIL areset_flags: got strobe %b win %b lose %b, expected 0 0 0", writeStrobe, win, lose);
    end
    exp_q.delete();
    repeat (3) @(negedge updateClk);
    reset_n = 1'b1;
    repeat (30) @(negedge updateClk);
    n_cmp++;
    if ({win, lose, level} !== 6'd0) begin
      n_err++; $display("FAIL areset_idle: got win %b lose %b level %0d, expected 0 0 0", win, lose, level);
    end
  endtask

  task automatic test_win_speedup();
    int exp_per[8];
    exp_per = '{10, 7, 4, 4, 4, 4, 4, 4};
    model_start();
    press();
    wait_drain(40);
    for (int r = 0; r < ROWS; r++) begin
      model_tick();
      wait_drain(40);
      n_cmp++;
      if ((last_wr - prev_wr) != exp_per[r]) begin
        n_err++; $display("FAIL step_period_row%0d: got %0d cycles, expected %0d", r, last_wr - prev_wr, exp_per[r]);
      end
      model_press();
      press();
      wait_drain(20);
    end
    repeat (20) @(negedge updateClk);
    n_cmp++;
    if ({win, lose} !== 2'b10) begin n_err++; $display("FAIL win_flags: got win %b lose %b, expected 1 0", win, lose); end
    n_cmp++;
    if (level !== 4'd8) begin n_err++; $display("FAIL win_level: got %0d, expected 8", level); end
    press();
    n_cmp++;
    if ({win, lose, level} !== {2'b00, 4'd8}) begin
      n_err++; $display("FAIL win_exit: got win %b lose %b level %0d, expected 0 0 8", win, lose, level);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_lose();
    test_place_align();
    test_hold_and_same_tick();
    test_async_reset();
    test_win_speedup();
    repeat (5) @(negedge updateClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
